// File: rtl/pd_seq_gen.sv
// ============================================================================
//  Module      : pd_seq_gen
//  Description : Streams, in ascending order, every 4-bit value in a chosen
//                number class (prime, multiple of 3, both, or either). Each
//                value is offered on a valid/ready handshake, and the block
//                counts the values accepted in each run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pd_seq_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic       ready,
    output logic [3:0] value,
    output logic       valid,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic [4:0] count
);

    // Membership masks over the 4-bit value space: bit n set means n is a member
    localparam logic [15:0] c_prime_mask = 16'h28AC;  // 2,3,5,7,11,13
    localparam logic [15:0] c_div3_mask  = 16'h9249;  // 0,3,6,9,12,15

    localparam logic [1:0] c_sel_either = 2'b00;
    localparam logic [1:0] c_sel_prime  = 2'b01;
    localparam logic [1:0] c_sel_div3   = 2'b10;
    localparam logic [1:0] c_sel_both   = 2'b11;

    localparam logic [3:0] c_cand_max   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cand;
    logic [1:0]  r_sel_q;
    logic [3:0]  r_value;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_count;

    logic [15:0] w_mask;
    logic [15:0] w_above;
    logic        w_last;

    // Class mask selected by the select code latched at the start of the run
    always_comb begin
        w_mask = c_prime_mask | c_div3_mask;
        case (r_sel_q)
            c_sel_prime:  w_mask = c_prime_mask;
            c_sel_div3:   w_mask = c_div3_mask;
            c_sel_both:   w_mask = c_prime_mask & c_div3_mask;
            c_sel_either: w_mask = c_prime_mask | c_div3_mask;
            default:      w_mask = c_prime_mask | c_div3_mask;
        endcase
    end

    // The presented value is the last member when no mask bit above cand is set
    always_comb begin
        w_above = w_mask >> r_cand;
        w_last  = r_valid && (w_above[15:1] == 15'd0);
    end

    // Generator FSM: scan candidates upward, hold each member until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cand  <= 4'd0;
            r_sel_q <= 2'b00;
            r_value <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sel_q <= sel;
                        r_cand  <= 4'd0;
                        r_count <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_mask[r_cand]) begin
                        r_value <= r_cand;
                        r_valid <= 1'b1;
                        r_state <= S_PRESENT;
                    end else if (r_cand == c_cand_max) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cand  <= r_cand + 4'd1;
                    end
                end
                S_PRESENT: begin
                    // valid is always high here, so ready alone completes the handshake
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + 5'd1;
                        if (r_cand == c_cand_max) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cand  <= r_cand + 4'd1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not sampled here; a run begins only from IDLE
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign last  = w_last;
    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pd_seq_gen.sv
// ============================================================================
//  Module      : tb_pd_seq_gen
//  Description : Directed self-checking bench for pd_seq_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pd_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic       ready;
    logic [3:0] value;
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
    logic [4:0] count;

    int nvec;
    int nfail;

    pd_seq_gen dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sel   (sel),
        .ready (ready),
        .value (value),
        .valid (valid),
        .last  (last),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a presented value, check it, optionally hold ready low, then accept
    task automatic take(input string tag, input int ev, input bit el, input int hold);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_value"}, {28'd0, value}, ev);
        chk({tag, "_last"},  {31'd0, last},  {31'd0, el});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, {31'd0, valid}, 32'd1);
            chk({tag, "_hold_value"}, {28'd0, value}, ev);
            chk({tag, "_hold_last"},  {31'd0, last},  {31'd0, el});
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({tag, "_drop"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int ev;
        bit hit;
        int div3_vals[6];
        int any_vals[11];
        int prime_vals[6];

        div3_vals  = '{0, 3, 6, 9, 12, 15};
        any_vals   = '{0, 2, 3, 5, 6, 7, 9, 11, 12, 13, 15};
        prime_vals = '{2, 3, 5, 7, 11, 13};
        nvec  = 0;
        nfail = 0;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 2'b00;
        ready = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_last",  {31'd0, last},  32'd0);
        chk("rst_value", {28'd0, value}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Primes, ready tied high, cycle-exact: values after E3,E5,E8,E11,E16,E19; done after E22
        ready = 1'b1;
        sel   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            case (e)
                3:       begin hit = 1'b1; ev = 2;  end
                5:       begin hit = 1'b1; ev = 3;  end
                8:       begin hit = 1'b1; ev = 5;  end
                11:      begin hit = 1'b1; ev = 7;  end
                16:      begin hit = 1'b1; ev = 11; end
                19:      begin hit = 1'b1; ev = 13; end
                default: begin hit = 1'b0; ev = 0;  end
            endcase
            chk($sformatf("pr_valid_e%0d", e), {31'd0, valid}, {31'd0, hit});
            if (hit)
                chk($sformatf("pr_value_e%0d", e), {28'd0, value}, ev);
            chk($sformatf("pr_last_e%0d", e), {31'd0, last}, {31'd0, (e == 19)});
            chk($sformatf("pr_done_e%0d", e), {31'd0, done}, {31'd0, (e == 22)});
            chk($sformatf("pr_busy_e%0d", e), {31'd0, busy}, {31'd0, (e <= 22)});
        end
        ready = 1'b0;
        chk("pr_count", {27'd0, count}, 32'd6);

        // Both: only 3, then a silent scan of 4..15 before done
        sel   = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        take("both3", 3, 1'b1, 0);
        for (int i = 0; i < 11; i++) tick();
        chk("both_scan_done", {31'd0, done}, 32'd0);
        chk("both_scan_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("both_done", {31'd0, done}, 32'd1);
        chk("both_count", {27'd0, count}, 32'd1);
        // start coinciding with done is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("both_post_done", {31'd0, done}, 32'd0);
        chk("both_post_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("both_nostart_busy", {31'd0, busy}, 32'd0);

        // Either: 11 values, last only on 15, done straight after accepting 15
        sel   = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++)
            take($sformatf("any%0d", any_vals[i]), any_vals[i], (i == 10), 0);
        chk("any_done", {31'd0, done}, 32'd1);
        chk("any_count", {27'd0, count}, 32'd11);
        tick();
        chk("any_idle", {31'd0, busy}, 32'd0);

        // Primes with sel change and a start pulse mid-run: no restart
        sel   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        take("mr2", 2, 1'b0, 0);
        sel   = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 6; i++)
            take($sformatf("mr%0d", prime_vals[i]), prime_vals[i], (i == 5), 0);
        wait_done("mr");
        chk("mr_count", {27'd0, count}, 32'd6);
        tick();
        chk("mr_idle", {31'd0, busy}, 32'd0);

        // Multiples of 3, ready 1 on / 3 off; count restarts at 0
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("d3_count0", {27'd0, count}, 32'd0);
        chk("d3_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 6; i++)
            take($sformatf("d3_%0d", div3_vals[i]), div3_vals[i], (i == 5), 3);
        chk("d3_done", {31'd0, done}, 32'd1);
        chk("d3_count", {27'd0, count}, 32'd6);
        tick();
        chk("d3_idle", {31'd0, busy}, 32'd0);
        chk("d3_hold_count", {27'd0, count}, 32'd6);

        // Asynchronous reset while 7 is presented
        sel   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        take("ar2", 2, 1'b0, 0);
        take("ar3", 3, 1'b0, 0);
        take("ar5", 5, 1'b0, 0);
        begin
            int n;
            n = 0;
            while (valid !== 1'b1 && n < 64) begin
                tick();
                n++;
            end
        end
        chk("ar7_value", {28'd0, value}, 32'd7);
        chk("ar7_count", {27'd0, count}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_busy",  {31'd0, busy},  32'd0);
        chk("ar_done",  {31'd0, done},  32'd0);
        chk("ar_count", {27'd0, count}, 32'd0);
        chk("ar_value", {28'd0, value}, 32'd0);
        chk("ar_last",  {31'd0, last},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        take("post_rst2", 2, 1'b0, 0);
        chk("post_rst_count", {27'd0, count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
